// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage registers
package pipe_pkg;

  // Occupancy of a two-entry skid stage
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  // Side-effect control bits within the control payload
  localparam int CTRL_REGWRITE_BIT = 0;
  localparam int CTRL_MEMWRITE_BIT = 2;

  // Bits that must read 0 whenever no valid entry is presented
  localparam logic [7:0] DEFAULT_KILL_MASK =
    8'((1 << CTRL_REGWRITE_BIT) | (1 << CTRL_MEMWRITE_BIT));

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous reset
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline register with 2-entry skid, flush, kill mask
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CTRL_WIDTH = 8,
  parameter logic [CTRL_WIDTH-1:0] KILL_MASK  = CTRL_WIDTH'(DEFAULT_KILL_MASK),
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  pipe_state_t state, state_nxt;

  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl;
  logic [DATA_WIDTH-1:0] main_data, skid_data;

  logic accept, drain;
  logic load_main_in, load_main_skid, load_skid;

  // Handshake qualifiers; in_ready depends only on registered state and rst
  always_comb begin
    in_ready  = !rst && (state != PS_FULL);
    out_valid = (state != PS_EMPTY);
    accept    = in_valid && in_ready && !flush;
    drain     = out_valid && out_ready;
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PS_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next occupancy and which entry loads; flush overrides everything
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = PS_EMPTY;
    end else begin
      unique case (state)
        PS_EMPTY: begin
          if (accept) begin
            state_nxt    = PS_ONE;
            load_main_in = 1'b1;
          end
        end
        PS_ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = PS_FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (drain) begin
            state_nxt      = PS_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = PS_EMPTY;
        end
      endcase
    end
  end

  // Payload storage; flush leaves contents alone, only occupancy is cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  // Side-effect bits read 0 whenever nothing valid is presented
  always_comb begin
    out_data = main_data;
    if (out_valid) begin
      out_ctrl = main_ctrl;
    end else begin
      out_ctrl = main_ctrl & ~KILL_MASK;
    end
  end

  logic stall_inc;

  // Upstream offered a beat but was refused
  always_comb begin
    stall_inc = in_valid && !in_ready && !rst;
  end

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

endmodule
